// File: rtl/fifo_pkg.sv
// Shared async-FIFO definitions: default geometry and pointer code conversion.
package fifo_pkg;

    localparam int unsigned FIFO_ASIZE     = 4;
    localparam int unsigned FIFO_AF_THRESH = 2;

    // Upper bits of g must be zero; works for any pointer width up to 32.
    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b = g;
        for (int unsigned i = 1; i < 32; i++) begin
            b = b ^ (g >> i);
        end
        return b;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a multi-bit Gray-coded bus; synchronous active-high reset.
module sync_2ff #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q1;

    always_ff @(posedge clk) begin
        if (rst) begin
            q1 <= '0;
            q  <= '0;
        end else begin
            q1 <= d;
            q  <= q1;
        end
    end

endmodule

// File: rtl/wptr_full_ctrl.sv
// Write-side pointer and status logic of an async FIFO: Gray write pointer,
// full / almost-full / fill level against the synchronized read pointer, sticky overflow.
module wptr_full_ctrl
    import fifo_pkg::*;
#(
    parameter int unsigned ASIZE     = FIFO_ASIZE,
    parameter int unsigned AF_THRESH = FIFO_AF_THRESH
) (
    input  logic             wclk,
    input  logic             wrst,
    input  logic             winc,
    input  logic [ASIZE:0]   rptr,
    input  logic             wovf_clr,
    output logic [ASIZE:0]   wptr,
    output logic [ASIZE-1:0] waddr,
    output logic             wen,
    output logic             wfull,
    output logic             walmost_full,
    output logic [ASIZE:0]   wlevel,
    output logic             woverflow
);

    localparam int unsigned PW       = ASIZE + 1;
    localparam int unsigned DEPTH    = 1 << ASIZE;
    localparam logic [ASIZE:0] AF_LEVEL = PW'(DEPTH - AF_THRESH);

    logic [ASIZE:0] wbin;
    logic [ASIZE:0] wbinnext;
    logic [ASIZE:0] wgraynext;
    logic [ASIZE:0] wq2;
    logic [ASIZE:0] rq2bin;
    logic [ASIZE:0] level_next;
    logic [ASIZE:0] full_gray;

    sync_2ff #(
        .WIDTH(PW)
    ) u_rptr_sync (
        .clk(wclk),
        .rst(wrst),
        .d  (rptr),
        .q  (wq2)
    );

    always_comb begin
        wen        = winc & ~wfull;
        wbinnext   = wbin + PW'(wen);
        wgraynext  = (wbinnext >> 1) ^ wbinnext;
        rq2bin     = PW'(gray2bin(32'(wq2)));
        level_next = wbinnext - rq2bin;
        // Full: write pointer one lap ahead, i.e. top two Gray bits inverted.
        full_gray  = {~wq2[ASIZE:ASIZE-1], wq2[ASIZE-2:0]};
    end

    assign waddr = wbin[ASIZE-1:0];

    always_ff @(posedge wclk) begin
        if (wrst) begin
            wbin         <= '0;
            wptr         <= '0;
            wfull        <= 1'b0;
            walmost_full <= 1'b0;
            wlevel       <= '0;
            woverflow    <= 1'b0;
        end else begin
            wbin         <= wbinnext;
            wptr         <= wgraynext;
            wfull        <= (wgraynext == full_gray);
            walmost_full <= (level_next >= AF_LEVEL);
            wlevel       <= level_next;
            if (winc & wfull) begin
                woverflow <= 1'b1;
            end else if (wovf_clr) begin
                woverflow <= 1'b0;
            end
        end
    end

endmodule
